// File: rtl/leb128_pkg.sv
// Shared definitions for the LEB128 stream decoder and its helpers.
//   leb128_maxb(w) : bytes needed to carry a w-bit value (ceil(w/7))
//   leb128_lw(w)   : width of the byte-length field, clog2(maxb)+1
//   leb128_state_e : ACC collects chunks, DRAIN discards excess continuation bytes
package leb128_pkg;

    localparam int unsigned CONT_BIT = 7;
    localparam int unsigned CHUNK_W  = 7;

    typedef enum logic [0:0] {
        ACC,
        DRAIN
    } leb128_state_e;

    function automatic int unsigned leb128_maxb(input int unsigned w);
        return (w + CHUNK_W - 1) / CHUNK_W;
    endfunction

    function automatic int unsigned leb128_lw(input int unsigned w);
        return $clog2(leb128_maxb(w)) + 1;
    endfunction

endpackage

// File: rtl/leb128_last_chunk_chk.sv
// Unused-bit check on the final (MAXB-1) chunk of a W-bit LEB128 value.
//   chunk_i : 7-bit payload of the last permitted byte
//   ovf_o   : 1 when the chunk carries bits that do not fit in W
// Unsigned: bits above the U used bits must be zero. Signed: those bits plus the
// top used bit must all match (valid sign extension). U = 7 leaves nothing to check.
module leb128_last_chunk_chk
    import leb128_pkg::*;
#(
    parameter int unsigned W      = 32,
    parameter bit          SIGNED = 1'b0
) (
    input  logic [6:0] chunk_i,
    output logic       ovf_o
);

    localparam int unsigned MAXB = leb128_maxb(W);
    localparam int          U    = int'(W - CHUNK_W * (MAXB - 1));

    always_comb begin
        ovf_o = 1'b0;
        for (int b = 0; b < int'(CHUNK_W); b++) begin
            if (!SIGNED && b >= U) begin
                ovf_o = ovf_o | chunk_i[b];
            end
            if (SIGNED && b >= U - 1) begin
                ovf_o = ovf_o | (chunk_i[b] ^ chunk_i[6]);
            end
        end
    end

endmodule

// File: rtl/leb128_stream_unpack.sv
// Streaming LEB128 / SLEB128 decoder, one encoded byte per cycle.
//   clk, rst_n      : clock, async active-low reset
//   in_data_i       : encoded byte (bit 7 continuation, bits 6:0 chunk)
//   in_valid_i/in_ready_o   : input handshake; in_ready_o = !out_valid_o | out_ready_i
//   out_data_o      : decoded W-bit value
//   out_len_o       : bytes consumed minus one, saturating
//   out_err_o       : overflow or overlong encoding seen
//   out_valid_o/out_ready_i : registered result handshake
module leb128_stream_unpack
    import leb128_pkg::*;
#(
    parameter int unsigned W      = 32,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [W-1:0]             out_data_o,
    output logic [leb128_lw(W)-1:0]  out_len_o,
    output logic                     out_err_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i
);

    localparam int unsigned MAXB     = leb128_maxb(W);
    localparam int unsigned LW       = leb128_lw(W);
    localparam logic [LW-1:0] CNT_MAX  = '1;
    localparam logic [LW-1:0] LAST_IDX = LW'(MAXB - 1);

    leb128_state_e  state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic [LW-1:0]  out_len_q, out_len_d;
    logic           out_err_q, out_err_d;
    logic           out_valid_q, out_valid_d;

    logic           accept;
    logic           is_cont;
    logic [6:0]     chunk;
    logic           at_last;
    logic           last_ovf;
    logic [31:0]    shamt;
    logic [31:0]    fill_shamt;
    logic [W-1:0]   acc_upd;
    logic           err_upd;
    logic [W-1:0]   fill;
    logic [LW-1:0]  cnt_inc;

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign is_cont    = in_data_i[CONT_BIT];
    assign chunk      = in_data_i[CHUNK_W-1:0];
    assign at_last    = (state_q == ACC) && (cnt_q == LAST_IDX);
    assign shamt      = CHUNK_W * 32'(cnt_q);
    assign fill_shamt = CHUNK_W * (32'(cnt_q) + 32'd1);

    leb128_last_chunk_chk #(
        .W      (W),
        .SIGNED (SIGNED)
    ) u_last_chk (
        .chunk_i (chunk),
        .ovf_o   (last_ovf)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                ACC:     if (is_cont && at_last) state_d = DRAIN;
                DRAIN:   if (!is_cont) state_d = ACC;
                default: state_d = ACC;
            endcase
        end
    end

    // Datapath / output next-state logic
    always_comb begin
        acc_upd = acc_q;
        err_upd = err_q;
        if (state_q == ACC) begin
            // acc above chunk n is still zero, so OR places the chunk; the shift truncates at W-1
            acc_upd = acc_q | (W'(chunk) << shamt);
            if (at_last) begin
                err_upd = err_q | last_ovf | is_cont;
            end
        end

        // Sign fill above the terminating chunk; shift >= W yields zero for a full-width value
        fill = '0;
        if (SIGNED && (state_q == ACC) && chunk[6]) begin
            fill = {W{1'b1}} << fill_shamt;
        end

        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_data_d  = out_data_q;
        out_len_d   = out_len_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q && !out_ready_i;

        if (accept) begin
            if (is_cont) begin
                acc_d = acc_upd;
                cnt_d = cnt_inc;
                err_d = err_upd;
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = acc_upd | fill;
                out_len_d   = cnt_q;
                out_err_d   = err_upd;
                acc_d       = '0;
                cnt_d       = '0;
                err_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_data_q  <= '0;
            out_len_q   <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_data_q  <= out_data_d;
            out_len_q   <= out_len_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_len_o   = out_len_q;
    assign out_err_o   = out_err_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_leb128_stream_unpack.sv
// Directed bench: three decoders (u32, s32, u64) share one byte stream.
module tb_leb128_stream_unpack;
    import leb128_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;

    logic        u32_in_ready, u32_err, u32_valid;
    logic [31:0] u32_data;
    logic [3:0]  u32_len;
    logic        s32_in_ready, s32_err, s32_valid;
    logic [31:0] s32_data;
    logic [3:0]  s32_len;
    logic        u64_in_ready, u64_err, u64_valid;
    logic [63:0] u64_data;
    logic [4:0]  u64_len;

    int checks   = 0;
    int failures = 0;

    leb128_stream_unpack #(.W(32), .SIGNED(1'b0)) u_u32 (
        .clk (clk), .rst_n (rst_n), .in_data_i (in_data), .in_valid_i (in_valid),
        .in_ready_o (u32_in_ready), .out_data_o (u32_data), .out_len_o (u32_len),
        .out_err_o (u32_err), .out_valid_o (u32_valid), .out_ready_i (out_ready)
    );

    leb128_stream_unpack #(.W(32), .SIGNED(1'b1)) u_s32 (
        .clk (clk), .rst_n (rst_n), .in_data_i (in_data), .in_valid_i (in_valid),
        .in_ready_o (s32_in_ready), .out_data_o (s32_data), .out_len_o (s32_len),
        .out_err_o (s32_err), .out_valid_o (s32_valid), .out_ready_i (out_ready)
    );

    leb128_stream_unpack #(.W(64), .SIGNED(1'b0)) u_u64 (
        .clk (clk), .rst_n (rst_n), .in_data_i (in_data), .in_valid_i (in_valid),
        .in_ready_o (u64_in_ready), .out_data_o (u64_data), .out_len_o (u64_len),
        .out_err_o (u64_err), .out_valid_o (u64_valid), .out_ready_i (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte for one clock; in_valid is left high for back-to-back use.
    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        chk("in_ready_before_byte", {63'd0, u32_in_ready}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #12;
        chk("rst_valid",    {63'd0, u32_valid},    64'd0);
        chk("rst_data",     {32'd0, u32_data},     64'd0);
        chk("rst_len",      {60'd0, u32_len},      64'd0);
        chk("rst_err",      {63'd0, u32_err},      64'd0);
        chk("rst_in_ready", {63'd0, u32_in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // E5 8E 26 -> 624485
        send(8'hE5);
        send(8'h8E);
        chk("e5_8e_no_valid", {63'd0, u32_valid}, 64'd0);
        send(8'h26);
        chk("e5_valid", {63'd0, u32_valid}, 64'd1);
        chk("e5_data",  {32'd0, u32_data},  64'h0009_8765);
        chk("e5_len",   {60'd0, u32_len},   64'd2);
        chk("e5_err",   {63'd0, u32_err},   64'd0);

        // 00 then 7F back-to-back
        send(8'h00);
        chk("b2b0_valid", {63'd0, u32_valid}, 64'd1);
        chk("b2b0_data",  {32'd0, u32_data},  64'd0);
        chk("b2b0_len",   {60'd0, u32_len},   64'd0);
        send(8'h7F);
        chk("b2b1_valid", {63'd0, u32_valid}, 64'd1);
        chk("b2b1_data",  {32'd0, u32_data},  64'd127);
        chk("b2b1_len",   {60'd0, u32_len},   64'd0);
        chk("s32_7f",     {32'd0, s32_data},  64'hFFFF_FFFF);
        idle(1);
        chk("drop_valid", {63'd0, u32_valid}, 64'd0);
        chk("hold_data",  {32'd0, u32_data},  64'd127);

        // FF FF FF FF 0F -> max u32
        repeat (4) send(8'hFF);
        send(8'h0F);
        chk("max_data", {32'd0, u32_data}, 64'hFFFF_FFFF);
        chk("max_len",  {60'd0, u32_len},  64'd4);
        chk("max_err",  {63'd0, u32_err},  64'd0);

        // FF FF FF FF 1F -> overflow
        repeat (4) send(8'hFF);
        send(8'h1F);
        chk("ovf_err",  {63'd0, u32_err},  64'd1);
        chk("ovf_data", {32'd0, u32_data}, 64'hFFFF_FFFF);

        // 80 x5 00 -> overlong
        repeat (5) send(8'h80);
        chk("drain_state", {63'd0, u_u32.state_q}, {63'd0, DRAIN});
        send(8'h00);
        chk("olong_err",  {63'd0, u32_err},  64'd1);
        chk("olong_len",  {60'd0, u32_len},  64'd5);
        chk("olong_data", {32'd0, u32_data}, 64'd0);
        chk("olong_state", {63'd0, u_u32.state_q}, {63'd0, ACC});

        // Signed C0 BB 78 -> -123456
        send(8'hC0);
        send(8'hBB);
        send(8'h78);
        chk("s_neg_data", {32'd0, s32_data}, 64'hFFFE_1DC0);
        chk("s_neg_len",  {60'd0, s32_len},  64'd2);
        chk("s_neg_err",  {63'd0, s32_err},  64'd0);

        // Signed FF FF FF FF 7F -> -1
        repeat (4) send(8'hFF);
        send(8'h7F);
        chk("s_m1_data", {32'd0, s32_data}, 64'hFFFF_FFFF);
        chk("s_m1_err",  {63'd0, s32_err},  64'd0);
        chk("u_7f_err",  {63'd0, u32_err},  64'd1);

        // Signed FF FF FF FF 4F -> bad sign extension
        repeat (4) send(8'hFF);
        send(8'h4F);
        chk("s_4f_err", {63'd0, s32_err}, 64'd1);

        // Backpressure
        idle(1);
        out_ready = 1'b0;
        send(8'h05);
        chk("bp_first", {32'd0, u32_data}, 64'd5);
        in_data = 8'h2A;
        chk("bp_stall_ready", {63'd0, u32_in_ready}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_ready", {63'd0, u32_in_ready}, 64'd0);
            chk("bp_data",  {32'd0, u32_data},     64'd5);
            chk("bp_valid", {63'd0, u32_valid},    64'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {63'd0, u32_in_ready}, 64'd1);
        @(posedge clk);
        #1;
        chk("bp_swap_data",  {32'd0, u32_data},  64'h2A);
        chk("bp_swap_valid", {63'd0, u32_valid}, 64'd1);
        idle(1);
        chk("bp_drop_valid", {63'd0, u32_valid}, 64'd0);

        // Length saturation: 19 continuation bytes then 00
        repeat (19) send(8'h80);
        send(8'h00);
        chk("sat_len_u32", {60'd0, u32_len}, 64'd15);
        chk("sat_err_u32", {63'd0, u32_err}, 64'd1);
        chk("sat_len_u64", {59'd0, u64_len}, 64'd19);

        // W=64: FF x9 01 -> all ones
        repeat (9) send(8'hFF);
        send(8'h01);
        chk("u64_data", u64_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("u64_err",  {63'd0, u64_err}, 64'd0);
        chk("u64_len",  {59'd0, u64_len}, 64'd9);
        chk("u32_10b_err", {63'd0, u32_err}, 64'd1);
        chk("u32_10b_len", {60'd0, u32_len}, 64'd9);
        repeat (9) send(8'hFF);
        send(8'h03);
        chk("u64_03_err", {63'd0, u64_err}, 64'd1);

        // Reset mid-sequence
        send(8'hE5);
        send(8'h8E);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_data",  {32'd0, u32_data},  64'd0);
        chk("mrst_valid", {63'd0, u32_valid}, 64'd0);
        chk("mrst_len",   {60'd0, u32_len},   64'd0);
        chk("mrst_err",   {63'd0, u32_err},   64'd0);
        chk("mrst_u64",   u64_data,           64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h05);
        chk("post_rst_data", {32'd0, u32_data},  64'd5);
        chk("post_rst_len",  {60'd0, u32_len},   64'd0);
        chk("post_rst_err",  {63'd0, u32_err},   64'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/leb128_stream_unpack.md
Name: leb128_stream_unpack

Overview:
- Streaming LEB128 decoder: accepts one encoded byte per cycle on a valid/ready byte stream and accumulates the chunks.
- Emits the decoded W-bit integer, its zero-based byte length and an error flag on a registered valid/ready output.
- Parametrised successor of the 5-byte combinational u32 unpacker: any width, unsigned or signed (SLEB128), unbounded input length with overflow/overlong detection.
- Sits between the byte-oriented bitstream reader and the value consumers.

Parameters:
- W, 32, decoded value width (8..64).
- SIGNED, 0, 0 = ULEB128 (zero-extend), 1 = SLEB128 (sign-extend from last chunk bit 6).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  8  encoded byte; bit 7 = continuation, bits 6:0 = chunk.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- out_data  out  W  decoded value.
- out_len  out  LW  bytes consumed minus 1, saturating; LW = clog2(MAXB)+1.
- out_err  out  1  overflow or overlong encoding.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.

Behaviour:
- MAXB = ceil(W/7); U = W-7*(MAXB-1) is the number of used bits in chunk MAXB-1 (W=32: MAXB=5, U=4).
- Reset (async assert, sync release): out_valid=0, out_data=0, out_len=0, out_err=0, accumulator=0, byte count=0, error=0, state=ACC.
- in_ready = !out_valid | out_ready, combinational; it is 1 after reset. Non-terminating bytes are subject to this rule too.
- States:
  - ACC: collecting chunks 0..MAXB-1.
  - DRAIN: byte count is at least MAXB and continuation bytes are being discarded.
- Accepted byte, ACC, index n < MAXB:
  - Write chunk into acc[7n +: 7], truncated at W-1.
  - At n = MAXB-1, check the unused bits:
    - Unsigned: chunk[6:U] != 0 sets err.
    - Signed: chunk[6:U-1] not all equal sets err.
    - U=7: no check.
- Accepted continuation byte at n = MAXB-1: set err, go to DRAIN.
- Accepted byte in DRAIN: discard the chunk and count it. Stay in DRAIN while continuation=1.
- Terminating byte (bit 7 = 0), either state:
  - Next cycle: out_valid=1, out_data=final acc, out_len=count (saturating at 2^LW-1), out_err=err.
  - SIGNED=1, terminated in ACC at index n with 7(n+1) < W: bits [W-1:7(n+1)] = chunk bit 6.
  - acc, count and err clear; state returns to ACC.
- Latency: terminator accepted in cycle t gives out_valid in cycle t+1. Throughput is 1 byte/cycle, including back-to-back values.
- out_valid & out_ready with no new terminator: out_valid drops next cycle; data and len hold their last values.
- out_valid & out_ready with a new terminator in the same cycle: the new result replaces the old one, out_valid stays 1, no bubble.
- out_valid & !out_ready: in_ready=0. Output and accumulator hold unchanged.
- The async reset takes effect immediately mid-sequence. The partial value is discarded and not output.

Decomposition:
- leb128_pkg:
  - function leb128_maxb(W) and leb128_lw(W).
  - state enum {ACC, DRAIN}.
  - CONT_BIT=7, CHUNK_W=7.
- One combinational sub-module, leb128_last_chunk_chk:
  - Parameters W, SIGNED.
  - Input: chunk[6:0]. Output: ovf.
  - Implements the unused-bit check. It is reused by the planned encoder's self-check.

Test Plan:
- W=32, unsigned; bytes E5 8E 26, out_ready=1 -> out_data=0x00098765 (624485), out_len=2, out_err=0, out_valid one cycle after byte 26.
- Single 0x00, then 0x7F back-to-back -> two results 0 and 127, out_len=0 each, consecutive out_valid cycles, in_ready constantly 1.
- Bytes FF FF FF FF 0F -> 0xFFFFFFFF, len=4, err=0.
- Bytes FF FF FF FF 1F -> err=1, out_data=0xFFFFFFFF.
- Bytes 80 80 80 80 80 00 -> err=1, out_len=5, out_data=0, DRAIN entered at byte 5.
- SIGNED=1, W=32: 0x7F -> 0xFFFFFFFF.
- SIGNED=1, W=32: C0 BB 78 -> 0xFFFE1DC0 (-123456).
- SIGNED=1, W=32: FF FF FF FF 7F -> -1, err=0.
- SIGNED=1, W=32: FF FF FF FF 4F -> err=1.
- Backpressure: hold out_ready=0 after a result -> in_ready=0, out_data stable 10 cycles. Then pulse out_ready while a terminator is presented -> the new result is swapped in with out_valid held at 1.
- W=64, unsigned: 10 bytes FF x9 01 -> 0xFFFFFFFFFFFFFFFF, err=0. With a last byte of 03 -> err=1.
- Reset asserted after bytes E5 8E -> all outputs 0 immediately. After release, byte 05 -> out_data=5, len=0.
